// File: rtl/fp16_pkg.sv
// Shared binary16 field definitions, constants and the operand unpacker.
// FP16_SUBNORMAL_EN selects gradual underflow; otherwise subnormal inputs read as zero.
package fp16_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int SIG_W  = FRAC_W + 1;
    localparam int BIAS   = 15;

    localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(2 * BIAS + 1);
    localparam logic [15:0]      QNAN    = 16'h7E00;
    localparam logic [15:0]      POS_INF = 16'h7C00;

    // exp holds the effective exponent used for alignment, sig includes the hidden bit
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
        logic             is_zero;
        logic             is_inf;
        logic             is_nan;
    } fp16_unp_t;

    function automatic fp16_unp_t unpack(input logic [15:0] x);
        fp16_unp_t u;
        u.sign   = x[15];
        u.is_nan = (x[14:10] == EXP_MAX) && (x[9:0] != '0);
        u.is_inf = (x[14:10] == EXP_MAX) && (x[9:0] == '0);
`ifdef FP16_SUBNORMAL_EN
        u.exp     = (x[14:10] == '0) ? EXP_W'(1) : x[14:10];
        u.sig     = {(x[14:10] != '0), x[9:0]};
        u.is_zero = (x[14:0] == '0);
`else
        u.exp     = x[14:10];
        u.sig     = (x[14:10] == '0) ? '0 : {1'b1, x[9:0]};
        u.is_zero = (x[14:10] == '0);
`endif
        return u;
    endfunction

endpackage

// File: rtl/fp16_lzc.sv
// Leading-zero counter over the 11-bit significand plus guard bit; all-zero input gives 12.
module fp16_lzc (
    input  logic [11:0] din,
    output logic [3:0]  cnt
);

    always_comb begin
        cnt = 4'd12;
        for (int i = 0; i < 12; i++) begin
            if (din[i]) cnt = 4'(11 - i);
        end
    end

endmodule

// File: rtl/fp_16_adder.sv
// Two-stage binary16 adder: stage 1 unpacks, orders and aligns; stage 2 adds, normalizes, rounds.
// FP16_SUBNORMAL_EN enables subnormal operands/results; undefined flushes them to signed zero.
module fp_16_adder
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] numi1,
    input  logic [15:0] numi2,
    output logic [15:0] ans,
    output logic        sign1o,
    output logic        sign2o,
    output logic [4:0]  exp1o,
    output logic [4:0]  exp2o,
    output logic [4:0]  expdiffo,
    output logic        szo,
    output logic [4:0]  lambdao,
    output logic        flago,
    output logic [10:0] mro,
    output logic [4:0]  rexpo
);

    fp16_unp_t   ua, ub;
    logic        swap, sign_l, sign_s, lost, special;
    logic [4:0]  exp_l, exp_s, ediff;
    logic [10:0] sig_l, sig_s;
    logic [13:0] ext, shifted, aligned;
    logic [15:0] spec_val;

    logic        s1_special, s1_sign_l, s1_sub, s1_flag, s1_sign1, s1_sign2;
    logic [15:0] s1_spec_val;
    logic [4:0]  s1_exp_l, s1_exp1, s1_exp2, s1_expdiff;
    logic [10:0] s1_sig_l;
    logic [13:0] s1_sig_s;

    always_comb begin : stage1
        ua     = unpack(numi1);
        ub     = unpack(numi2);
        swap   = numi2[14:0] > numi1[14:0];
        sign_l = swap ? ub.sign : ua.sign;
        sign_s = swap ? ua.sign : ub.sign;
        exp_l  = swap ? ub.exp  : ua.exp;
        exp_s  = swap ? ua.exp  : ub.exp;
        sig_l  = swap ? ub.sig  : ua.sig;
        sig_s  = swap ? ua.sig  : ub.sig;
        // exponents never exceed 30 on this path, so the difference fits without saturating
        ediff   = exp_l - exp_s;
        ext     = {sig_s, 3'b000};
        shifted = ext >> ediff;
        lost    = |(ext & ~(14'h3fff << ediff));
        aligned = {shifted[13:1], shifted[0] | lost};

        special  = 1'b1;
        spec_val = QNAN;
        if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && (ua.sign != ub.sign)))
            spec_val = QNAN;
        else if (ua.is_inf)
            spec_val = numi1;
        else if (ub.is_inf)
            spec_val = numi2;
        else if (ua.is_zero && ub.is_zero)
            spec_val = {ua.sign & ub.sign, 15'd0};
        else
            special = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_special  <= 1'b0;
            s1_spec_val <= '0;
            s1_sign_l   <= 1'b0;
            s1_sub      <= 1'b0;
            s1_exp_l    <= '0;
            s1_sig_l    <= '0;
            s1_sig_s    <= '0;
            s1_flag     <= 1'b0;
            s1_sign1    <= 1'b0;
            s1_sign2    <= 1'b0;
            s1_exp1     <= '0;
            s1_exp2     <= '0;
            s1_expdiff  <= '0;
        end else begin
            s1_special  <= special;
            s1_spec_val <= spec_val;
            s1_sign_l   <= sign_l;
            s1_sub      <= sign_l ^ sign_s;
            s1_exp_l    <= exp_l;
            s1_sig_l    <= sig_l;
            s1_sig_s    <= aligned;
            s1_flag     <= swap;
            s1_sign1    <= numi1[15];
            s1_sign2    <= numi2[15];
            s1_exp1     <= numi1[14:10];
            s1_exp2     <= numi2[14:10];
            s1_expdiff  <= ediff;
        end
    end

    logic [14:0] op_l, op_s, sum;
    logic [13:0] norm;
    logic [11:0] sig_r;
    logic [10:0] sig_f;
    logic [5:0]  e_pre, e;
    logic [4:0]  limit, sh, lam, lam_d;
    logic [3:0]  lz;
    logic        round_up, tiny;
    logic [15:0] ans_d;

    fp16_lzc u_lzc (
        .din (sum[13:2]),
        .cnt (lz)
    );

    always_comb begin : stage2
        op_l  = {1'b0, s1_sig_l, 3'b000};
        op_s  = {1'b0, s1_sig_s};
        sum   = s1_sub ? (op_l - op_s) : (op_l + op_s);
        limit = s1_exp_l - 5'd1;
        sh    = ({1'b0, lz} < limit) ? {1'b0, lz} : limit;

        if (sum[14]) begin
            norm  = {sum[14:2], sum[1] | sum[0]};
            e_pre = {1'b0, s1_exp_l} + 6'd1;
            lam   = 5'd0;
        end else begin
            // a shift capped by the exponent leaves the hidden bit clear: subnormal
            norm  = sum[13:0] << sh;
            e_pre = norm[13] ? ({1'b0, s1_exp_l} - {1'b0, sh}) : 6'd0;
            lam   = sh;
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        sig_r    = {1'b0, norm[13:3]} + {11'd0, round_up};
        sig_f    = sig_r[11] ? sig_r[11:1] : sig_r[10:0];
        e        = e_pre + {5'd0, sig_r[11]};
        if ((e == 6'd0) && sig_f[10]) e = 6'd1;

`ifdef FP16_SUBNORMAL_EN
        tiny = 1'b0;
`else
        tiny = (e == 6'd0);
`endif

        ans_d = '0;
        lam_d = lam;
        if (s1_special) begin
            ans_d = s1_spec_val;
            lam_d = 5'd0;
        end else if (sum == '0) begin
            ans_d = 16'h0000;
            lam_d = 5'd0;
        end else if (e >= {1'b0, EXP_MAX}) begin
            ans_d = {s1_sign_l, POS_INF[14:0]};
        end else if (tiny) begin
            ans_d = {s1_sign_l, 15'd0};
        end else begin
            ans_d = {s1_sign_l, e[4:0], sig_f[9:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ans      <= '0;
            sign1o   <= 1'b0;
            sign2o   <= 1'b0;
            exp1o    <= '0;
            exp2o    <= '0;
            expdiffo <= '0;
            szo      <= 1'b0;
            lambdao  <= '0;
            flago    <= 1'b0;
            mro      <= '0;
            rexpo    <= '0;
        end else begin
            ans      <= ans_d;
            sign1o   <= s1_sign1;
            sign2o   <= s1_sign2;
            exp1o    <= s1_exp1;
            exp2o    <= s1_exp2;
            expdiffo <= s1_expdiff;
            szo      <= ans_d[15];
            lambdao  <= lam_d;
            flago    <= s1_flag;
            mro      <= {(ans_d[14:10] != 5'd0), ans_d[9:0]};
            rexpo    <= ans_d[14:10];
        end
    end

endmodule

// File: tb/tb_fp_16_adder.sv
// Streaming bench for fp_16_adder against an exact-integer reference model.
module tb_fp_16_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] numi1, numi2, ans;
    logic        sign1o, sign2o, szo, flago;
    logic [4:0]  exp1o, exp2o, expdiffo, lambdao, rexpo;
    logic [10:0] mro;
    logic [55:0] all_out;

    int total = 0;
    int bad   = 0;

    fp_16_adder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .numi1    (numi1),
        .numi2    (numi2),
        .ans      (ans),
        .sign1o   (sign1o),
        .sign2o   (sign2o),
        .exp1o    (exp1o),
        .exp2o    (exp2o),
        .expdiffo (expdiffo),
        .szo      (szo),
        .lambdao  (lambdao),
        .flago    (flago),
        .mro      (mro),
        .rexpo    (rexpo)
    );

    always #5 clk = ~clk;

    assign all_out = {ans, sign1o, sign2o, exp1o, exp2o, expdiffo, szo, lambdao, flago, mro, rexpo};

    typedef struct {
        logic [15:0] ans;
        logic        flag;
        logic [4:0]  expdiff;
        logic [4:0]  lambda;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        res_t        m;
        logic [15:0] want;
        bit          has_want;
    } rec_t;

    rec_t q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Operands become exact integers in units of 2^-24; the sum is rounded from that exact value.
    function automatic res_t ref_add(input logic [15:0] a, input logic [15:0] b);
        res_t        r;
        int          ea, eb, eea, eeb, effl, e, epre, p, sh, expf;
        longint      va, vb, sum, mag, qq, rem, half;
        bit          sub_en, sgn;
        logic [15:0] res;
`ifdef FP16_SUBNORMAL_EN
        sub_en = 1'b1;
`else
        sub_en = 1'b0;
`endif
        ea  = int'(a[14:10]);
        eb  = int'(b[14:10]);
        eea = (ea == 0) ? int'(sub_en) : ea;
        eeb = (eb == 0) ? int'(sub_en) : eb;
        r.flag    = (b[14:0] > a[14:0]);
        r.expdiff = 5'(r.flag ? eeb - eea : eea - eeb);
        effl      = r.flag ? eeb : eea;
        r.lambda  = 5'd0;
        if ((ea == 31 && a[9:0] != 0) || (eb == 31 && b[9:0] != 0))
            res = 16'h7E00;
        else if (ea == 31 && eb == 31 && a[15] != b[15])
            res = 16'h7E00;
        else if (ea == 31)
            res = a;
        else if (eb == 31)
            res = b;
        else begin
            va = (ea == 0) ? (sub_en ? longint'(a[9:0]) : 64'sd0) : (longint'(1024 + int'(a[9:0])) <<< (ea - 1));
            vb = (eb == 0) ? (sub_en ? longint'(b[9:0]) : 64'sd0) : (longint'(1024 + int'(b[9:0])) <<< (eb - 1));
            if (a[15]) va = -va;
            if (b[15]) vb = -vb;
            sum = va + vb;
            if (sum == 0) begin
                res = {a[15] & b[15], 15'h0};
            end else begin
                sgn = (sum < 0);
                mag = sgn ? -sum : sum;
                p = 0;
                for (int i = 0; i < 48; i++) if (mag[i]) p = i;
                e    = (p >= 10) ? p - 9 : 1;
                epre = e;
                sh   = e - 1;
                qq   = mag >> sh;
                rem  = mag - (qq << sh);
                if (sh > 0) begin
                    half = longint'(1) << (sh - 1);
                    if (rem > half || (rem == half && qq[0])) qq++;
                end
                if (qq == 2048) begin
                    qq = 1024;
                    e++;
                end
                if (e >= 31) begin
                    res = {sgn, 15'h7C00};
                end else begin
                    expf = (qq >= 1024) ? e : 0;
                    res  = {sgn, 5'(expf), qq[9:0]};
                    if (!sub_en && expf == 0) res = {sgn, 15'h0};
                end
                r.lambda = (effl > epre) ? 5'(effl - epre) : 5'd0;
            end
        end
        r.ans = res;
        return r;
    endfunction

    task automatic check_rec(input rec_t r);
        logic [10:0] want_mro;
        want_mro = {(r.m.ans[14:10] != 5'd0), r.m.ans[9:0]};
        chk("ans",      64'(ans),      64'(r.m.ans));
        chk("sign1o",   64'(sign1o),   64'(r.a[15]));
        chk("sign2o",   64'(sign2o),   64'(r.b[15]));
        chk("exp1o",    64'(exp1o),    64'(r.a[14:10]));
        chk("exp2o",    64'(exp2o),    64'(r.b[14:10]));
        chk("expdiffo", 64'(expdiffo), 64'(r.m.expdiff));
        chk("flago",    64'(flago),    64'(r.m.flag));
        chk("lambdao",  64'(lambdao),  64'(r.m.lambda));
        chk("szo",      64'(szo),      64'(r.m.ans[15]));
        chk("mro",      64'(mro),      64'(want_mro));
        chk("rexpo",    64'(rexpo),    64'(r.m.ans[14:10]));
        if (r.has_want) chk("ans_directed", 64'(ans), 64'(r.want));
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [15:0] want, input bit has_want);
        rec_t r;
        numi1 = a;
        numi2 = b;
        r.a = a;
        r.b = b;
        r.m = ref_add(a, b);
        r.want = want;
        r.has_want = has_want;
        q.push_back(r);
    endtask

    task automatic step(input logic [15:0] a, input logic [15:0] b, input logic [15:0] want, input bit has_want);
        @(negedge clk);
        if (q.size() >= 2) check_rec(q.pop_front());
        push(a, b, want, has_want);
    endtask

    logic [15:0] dir_a [13] = '{16'h3800, 16'h3C00, 16'h3C00, 16'h7BFF, 16'h7C00, 16'h3C00, 16'h3C01,
                                16'h0001, 16'h7D00, 16'hFC00, 16'h8000, 16'h0000, 16'h0000};
    logic [15:0] dir_b [13] = '{16'hB700, 16'h3C00, 16'hBC00, 16'h7BFF, 16'hFC00, 16'h1000, 16'h1000,
                                16'h0001, 16'h3C00, 16'h4000, 16'h8000, 16'h8000, 16'h3555};
    logic [15:0] dir_w [13];

    initial begin
        logic [15:0] a, b;
        logic [4:0]  ex;
        int          mode;

        dir_w = '{16'h2C00, 16'h4000, 16'h0000, 16'h7C00, 16'h7E00, 16'h3C00, 16'h3C02,
                  16'h0000, 16'h7E00, 16'hFC00, 16'h8000, 16'h0000, 16'h3555};
`ifdef FP16_SUBNORMAL_EN
        dir_w[7] = 16'h0002;
`endif
        rst_n = 1'b0;
        numi1 = 16'h3C00;
        numi2 = 16'h3C00;
        repeat (3) @(negedge clk);
        chk("reset_state", 64'(all_out), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) step(dir_a[i], dir_b[i], dir_w[i], 1'b1);

        for (int i = 0; i < 3000; i++) begin
            a    = 16'($urandom);
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: b = 16'($urandom);
                1: begin
                    ex = 5'(a[14:10] + 5'($urandom_range(0, 4)) - 5'd2);
                    b  = {1'($urandom), ex, 10'($urandom)};
                end
                2: b = {~a[15], a[14:10], a[9:0] ^ 10'($urandom_range(0, 15))};
                default: begin
                    a = {1'($urandom), 5'($urandom_range(0, 2)), 10'($urandom)};
                    b = {1'($urandom), 5'($urandom_range(0, 2)), 10'($urandom)};
                end
            endcase
            step(a, b, 16'h0, 1'b0);
        end

        // asynchronous reset in the middle of a back-to-back stream
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("reset_async", 64'(all_out), 64'd0);
        q.delete();
        @(negedge clk);
        chk("reset_hold", 64'(all_out), 64'd0);
        rst_n = 1'b1;
        push(16'h3C00, 16'h3C00, 16'h4000, 1'b1);
        @(negedge clk);
        chk("reset_lat1", 64'(ans), 64'd0);
        push(16'h3800, 16'hB700, 16'h2C00, 1'b1);
        step(16'h3C01, 16'h1000, 16'h3C02, 1'b1);
        step(16'h0000, 16'h0000, 16'h0000, 1'b1);
        step(16'h0000, 16'h0000, 16'h0000, 1'b1);
        step(16'h0000, 16'h0000, 16'h0000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
